// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and constants for the countdown timer
// Contents: FSM state encoding, register word offsets, CTRL bit positions,
// and the counting mode encodings.
package timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } timer_state_e;

  // Byte offsets of the registers inside the 16-byte window
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;

  // CTRL field positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/byte_merge.sv
// rtl/byte_merge.sv - byte-lane merge of an old word with new write data
// Ports:
//   old_i     in  32  current word contents
//   new_i     in  32  lane-aligned write data
//   byteen_i  in  4   lane enables, bit i selects byte i from new_i
//   merged_o  out 32  resulting word
module byte_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  byteen_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < 4; i++) begin
      if (byteen_i[i]) begin
        merged_o[8*i +: 8] = new_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped 32-bit countdown timer with interrupt
// Ports:
//   clk     in  1   clock, all state on the rising edge
//   reset   in  1   asynchronous active-high reset
//   addr    in  32  CPU byte address (addr[1:0] ignored)
//   byteen  in  4   byte-lane write enables, 0 = no write
//   wdata   in  32  lane-aligned write data
//   rdata   out 32  combinational read data for addr
//   irq     out 1   interrupt request (PEND & IM)
module timer_dev
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  timer_state_e state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic        pend_q, pend_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;

  logic        hit;
  logic [1:0]  word_sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic [31:0] ctrl_word;
  logic [31:0] merge_old;
  logic [31:0] merge_new;
  logic        int_entry;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  assign hit       = (addr[31:4] == BASE[31:4]);
  assign word_sel  = addr[3:2];
  assign wr_ctrl   = hit && (byteen != 4'b0000) && (word_sel == OFF_CTRL[3:2]);
  assign wr_preset = hit && (byteen != 4'b0000) && (word_sel == OFF_PRESET[3:2]);
  assign ctrl_word = {28'd0, im_q, mode_q, en_q};

  // One merger serves both writable registers; the addressed one is the old word.
  assign merge_old = (word_sel == OFF_CTRL[3:2]) ? ctrl_word : preset_q;

  byte_merge u_byte_merge (
    .old_i    (merge_old),
    .new_i    (wdata),
    .byteen_i (byteen),
    .merged_o (merge_new)
  );

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    mode_d    = mode_q;
    im_d      = im_q;
    pend_d    = pend_q;
    preset_d  = preset_q;
    count_d   = count_q;
    int_entry = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d   = 32'd0;
          pend_d    = 1'b1;
          int_entry = 1'b1;
          state_d   = S_INT;
        end
      end
      S_INT: begin
        if (mode_q == MODE_RELOAD) begin
          pend_d  = 1'b0;
          state_d = S_LOAD;
        end else begin
          en_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus writes are applied after the FSM so a CTRL write overrides the
    // INT-state EN clear. PEND set on INT entry still beats the write clear.
    if (wr_ctrl) begin
      en_d   = merge_new[CTRL_EN];
      mode_d = merge_new[CTRL_MODE_HI:CTRL_MODE_LO];
      im_d   = merge_new[CTRL_IM];
      if (mode_q != MODE_RELOAD && !int_entry) pend_d = 1'b0;
    end
    if (wr_preset) preset_d = merge_new;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      pend_q   <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      pend_q   <= pend_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

  assign irq = pend_q & im_q;

  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (word_sel)
        OFF_CTRL[3:2]:   rdata = ctrl_word;
        OFF_PRESET[3:2]: rdata = preset_q;
        OFF_COUNT[3:2]:  rdata = count_q;
        default:         rdata = 32'd0;
      endcase
    end
  end

endmodule
